// File: rtl/mem_port_arbiter.sv
// Two-requester (instr fetch / data load-store) arbiter for a single-outstanding memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  proto_err_o
);

    typedef enum logic [1:0] {StIdle, StWaitI, StWaitD} state_e;

    state_e r_state;
    logic   r_lock;
    logic   r_lock_data;
    logic   r_err;
    logic   w_elig;
    logic   w_sel_data;
    logic   w_req;
    logic   w_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic   r_rr_data;
`endif

    always_comb begin
        // Back-to-back issue is allowed in the cycle the previous response returns.
        w_elig = rst_n && ((r_state == StIdle) || mem_rvalid_i);
        if (r_lock && (r_lock_data ? data_req_i : instr_req_i)) begin
            w_sel_data = r_lock_data;
        end else if (data_req_i && instr_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_sel_data = r_rr_data;
`else
            w_sel_data = 1'b1;
`endif
        end else begin
            w_sel_data = data_req_i;
        end
        w_req   = w_elig && (w_sel_data ? data_req_i : instr_req_i);
        w_grant = w_req && mem_gnt_i;
    end

    always_comb begin
        mem_req_o   = w_req;
        mem_we_o    = w_req && w_sel_data && data_we_i;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_req) begin
            mem_be_o    = w_sel_data ? data_be_i : {BE_WIDTH{1'b1}};
            mem_addr_o  = w_sel_data ? data_addr_i : instr_addr_i;
            mem_wdata_o = w_sel_data ? data_wdata_i : '0;
        end
        instr_gnt_o    = w_grant && !w_sel_data;
        data_gnt_o     = w_grant && w_sel_data;
        instr_rvalid_o = (r_state == StWaitI) && mem_rvalid_i;
        data_rvalid_o  = (r_state == StWaitD) && mem_rvalid_i;
        instr_rdata_o  = (r_state == StWaitI) ? mem_rdata_i : '0;
        data_rdata_o   = (r_state == StWaitD) ? mem_rdata_i : '0;
        proto_err_o    = r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_lock      <= 1'b0;
            r_lock_data <= 1'b0;
            r_err       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_data   <= 1'b1;
`endif
        end else begin
            if (w_grant) begin
                r_state <= w_sel_data ? StWaitD : StWaitI;
                r_lock  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                r_rr_data <= !w_sel_data;
`endif
            end else begin
                if ((r_state != StIdle) && mem_rvalid_i) begin
                    r_state <= StIdle;
                end
                if (w_req) begin
                    r_lock      <= 1'b1;
                    r_lock_data <= w_sel_data;
                end
            end
            if (((r_state == StIdle) && mem_rvalid_i) || (mem_gnt_i && !w_req)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the memory word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width.
REQ-003 The block SHALL have parameter BE_WIDTH, default 4, giving the byte-enable width.
REQ-004 Reset SHALL be rst_n, asynchronous, active-low; the clock SHALL be clk.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  ADDR_WIDTH  fetch address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch data valid
- instr_rdata_o  out  DATA_WIDTH  fetch data
- data_req_i  in  1  load/store request
- data_we_i  in  1  store when 1
- data_be_i  in  BE_WIDTH  byte enables
- data_addr_i  in  ADDR_WIDTH  data address
- data_wdata_i  in  DATA_WIDTH  store data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  DATA_WIDTH  load data
- mem_req_o  out  1  shared-port request
- mem_we_o  out  1  shared-port write enable
- mem_be_o  out  BE_WIDTH  shared-port byte enables
- mem_addr_o  out  ADDR_WIDTH  shared-port address
- mem_wdata_o  out  DATA_WIDTH  shared-port write data
- mem_gnt_i  in  1  shared-port grant
- mem_rvalid_i  in  1  shared-port response valid, exactly one cycle after grant
- mem_rdata_i  in  DATA_WIDTH  shared-port read data
- proto_err_o  out  1  sticky protocol-error flag

Function
REQ-006 The block SHALL implement the states IDLE, WAIT_I and WAIT_D, giving at most one outstanding transaction on the shared port.
REQ-007 A request SHALL be eligible in IDLE, or in WAIT_x during the same cycle that mem_rvalid_i=1 (back-to-back); otherwise mem_req_o SHALL be 0.
REQ-008 mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o SHALL combinationally reflect the winning requester; for an instruction winner, we=0 and be=all-ones.
REQ-009 mem_gnt_i SHALL be forwarded combinationally to the winner's gnt output only; the loser's gnt SHALL be 0.
REQ-010 Winner selection SHALL follow the policy defined in Configuration.
REQ-011 If the winner is not granted, the decision SHALL be locked, and the same requester SHALL win every subsequent eligible cycle until it is granted, regardless of the other request.
REQ-012 On grant to instr, the next state SHALL be WAIT_I; on grant to data, WAIT_D.
REQ-013 WAIT_x with mem_rvalid_i=1 and no new grant SHALL go to IDLE; WAIT_x with mem_rvalid_i=0 SHALL hold.
REQ-014 mem_rvalid_i SHALL be routed to instr_rvalid_o in WAIT_I and to data_rvalid_o in WAIT_D, same cycle (combinational).
REQ-015 The owner's rdata output SHALL equal mem_rdata_i; the non-owner's rdata output SHALL be 0.
REQ-016 A data store SHALL still produce data_rvalid_o (write acknowledge).
REQ-017 mem_rvalid_i=1 in IDLE SHALL be ignored (no rvalid output) and SHALL set proto_err_o.
REQ-018 mem_gnt_i=1 while mem_req_o=0 SHALL set proto_err_o.
REQ-019 proto_err_o SHALL be cleared only by reset.

Reset
REQ-020 On reset assertion, state SHALL be IDLE, the lock SHALL clear, the round-robin pointer SHALL favour data, and proto_err_o SHALL be 0.
REQ-021 During reset, all gnt/rvalid/mem_req outputs SHALL be 0.
REQ-022 A transaction in flight at reset SHALL be abandoned; any rvalid arriving after reset release SHALL be handled per REQ-017.

Configuration
REQ-023 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-024 With ARB_ROUND_ROBIN_EN defined, on a simultaneous request the requester not granted most recently SHALL win, and the pointer SHALL update on each grant.
REQ-025 Without ARB_ROUND_ROBIN_EN, data SHALL always have fixed priority over instr, and no pointer register SHALL exist.

Verification
REQ-026 Bench: instr_req only, addr 0x004, mem_gnt immediate -> instr_gnt_o=1 in cycle 0, instr_rvalid_o=1 with rdata 0x00000013 in cycle 1, state back to IDLE.
REQ-027 Bench: both requests, mem_gnt held low for 3 cycles, instr_req dropped meanwhile -> data stays on mem_addr_o the whole time (lock), data_gnt_o only in cycle 3.
REQ-028 Bench: back-to-back, data load granted cycle 0, instr granted cycle 1 alongside rvalid -> data_rvalid_o in cycle 1, instr_rvalid_o in cycle 2, no bubble.
REQ-029 Bench: continuous dual requests for 6 grants -> with macro, grants alternate D,I,D,I,D,I; without macro, 6 data grants and instr_gnt_o=0.
REQ-030 Bench: mem_rvalid_i pulse in IDLE -> no rvalid output, proto_err_o=1 until rst_n low; reset in WAIT_D -> IDLE, all outputs 0.
